// File: rtl/serial_out_pkg.sv
// ---------------------------------------------------------------------------
// serial_out_pkg
// Shared definitions for the parallel-to-serial output stage:
//   - state_t       : transfer FSM states
//   - phase_cnt_w() : width of the sclk half-period phase counter (min 1)
//   - bit_cnt_w()   : width of the bits-remaining counter (holds 0..WIDTH)
// ---------------------------------------------------------------------------
package serial_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LATCH = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // $clog2(1) is 0, so a divide-by-1 or divide-by-2 counter still gets one bit.
  function automatic int phase_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Must represent WIDTH itself, hence WIDTH+1 values.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sclk_phase_gen.sv
// ---------------------------------------------------------------------------
// sclk_phase_gen
// Counts clk cycles within one sclk half-period (0..DIV-1) and flags the
// last cycle of the half-period.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  hold the counter at phase 0 (driven while the FSM is idle)
//   tick  out high during the final phase cycle (phase == DIV-1)
// ---------------------------------------------------------------------------
module sclk_phase_gen
  import serial_out_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int PW = phase_cnt_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == LAST);
  assign tick   = w_last;

  // Wrapping on the last phase doubles as the clear at every LOW/HIGH/LATCH
  // state change, since those changes only ever happen on a tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_phase <= '0;
    end else if (w_last) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/serial_shift_out.sv
// ---------------------------------------------------------------------------
// serial_shift_out
// Parallel-to-serial output stage for a shift-register LED/segment chain.
// A start request captures PData; the word is shifted out on sdata/sclk
// (downstream samples on sclk rising edge), then latch is pulsed for one
// sclk half-period and done pulses for one clk cycle.
// Parameters:
//   WIDTH     bits per transfer (>= 2)
//   DIV       clk cycles per sclk half-period (>= 1)
//   MSB_FIRST 1 = MSB first, 0 = LSB first
// Ports:
//   clk   in            system clock, rising edge
//   rst   in            synchronous active-high reset
//   start in            transfer request (accepted in IDLE or FIN only)
//   PData in  [WIDTH]   word captured on an accepted start
//   busy  out           transfer in progress (LOW/HIGH/LATCH)
//   done  out           one-cycle end-of-transfer pulse
//   sdata out           serial data
//   sclk  out           serial clock
//   latch out           parallel-load strobe for the downstream chain
// All outputs are registered.
// ---------------------------------------------------------------------------
module serial_shift_out
  import serial_out_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV       = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] PData,
  output logic             busy,
  output logic             done,
  output logic             sdata,
  output logic             sclk,
  output logic             latch
);

  localparam int BW = bit_cnt_w(WIDTH);
  localparam logic [BW-1:0] BITS_INIT = BW'(WIDTH);

  // Bit presented on sdata: the end of the shift register nearest the output.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the next bit into the head position, zero filling behind it.
  function automatic logic [WIDTH-1:0] shift_toward_head(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic             r_busy;
  logic             r_done;
  logic             r_sdata;
  logic             r_sclk;
  logic             r_latch;

  logic             w_tick;
  logic             w_phase_clr;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  // Phase counter sits at 0 whenever no half-period is being timed, so the
  // first LOW phase after a capture always lasts exactly DIV cycles.
  assign w_phase_clr = (r_state == ST_IDLE) || (r_state == ST_FIN);

  // FIN accepts start as well as IDLE, giving back-to-back transfers.
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
  assign w_shifted = shift_toward_head(r_shreg);

  sclk_phase_gen #(
    .DIV (DIV)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clear (w_phase_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sdata  <= 1'b0;
      r_sclk   <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        // Outputs are registered, so the first data bit is driven from
        // PData directly to be valid in the first LOW cycle.
        r_state  <= ST_LOW;
        r_shreg  <= PData;
        r_bitcnt <= BITS_INIT;
        r_busy   <= 1'b1;
        r_sdata  <= head_bit(PData);
        r_sclk   <= 1'b0;
        r_latch  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy  <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
          end

          ST_LOW: begin
            if (w_tick) begin
              r_state <= ST_HIGH;
              r_sclk  <= 1'b1;
            end
          end

          ST_HIGH: begin
            if (w_tick) begin
              r_shreg  <= w_shifted;
              r_bitcnt <= r_bitcnt - BW'(1);
              r_sclk   <= 1'b0;
              // Exit on the count reaching 1, never relying on a wrap to 0.
              if (r_bitcnt == BW'(1)) begin
                r_state <= ST_LATCH;
                r_latch <= 1'b1;
                r_sdata <= 1'b0;
              end else begin
                r_state <= ST_LOW;
                r_sdata <= head_bit(w_shifted);
              end
            end
          end

          ST_LATCH: begin
            if (w_tick) begin
              r_state <= ST_FIN;
              r_latch <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end

          ST_FIN: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_sdata <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sdata = r_sdata;
  assign sclk  = r_sclk;
  assign latch = r_latch;

endmodule

// File: tb/tb_serial_shift_out.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_out
// Two instances: dut_a with defaults (WIDTH=32, DIV=2, MSB first) and
// dut_b (WIDTH=32, DIV=1, LSB first). Cycle numbering: the edge that samples
// start is edge 0; "cycle N" is the interval following edge N-1, observed
// 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_serial_shift_out;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [31:0] pdata_a = '0;
  logic        busy_a, done_a, sdata_a, sclk_a, latch_a;

  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [31:0] pdata_b = '0;
  logic        busy_b, done_b, sdata_b, sclk_b, latch_b;

  serial_shift_out dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .start (start_a),
    .PData (pdata_a),
    .busy  (busy_a),
    .done  (done_a),
    .sdata (sdata_a),
    .sclk  (sclk_a),
    .latch (latch_a)
  );

  serial_shift_out #(.WIDTH(32), .DIV(1), .MSB_FIRST(0)) dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .start (start_b),
    .PData (pdata_b),
    .busy  (busy_b),
    .done  (done_b),
    .sdata (sdata_b),
    .sclk  (sclk_b),
    .latch (latch_b)
  );

  // Receivers modelling the downstream chain: sample sdata at each sclk rise.
  logic        prev_sclk_a = 1'b0, prev_sclk_b = 1'b0;
  logic [31:0] rx_a = '0, rx_b = '0;
  int          nbits_a = 0, nlatch_a = 0, ndone_a = 0;
  int          nbits_b = 0, nlatch_b = 0, ndone_b = 0;

  always @(negedge clk) begin
    if (sclk_a && !prev_sclk_a) begin
      rx_a    <= {rx_a[30:0], sdata_a};
      nbits_a <= nbits_a + 1;
    end
    prev_sclk_a <= sclk_a;
    if (latch_a) nlatch_a <= nlatch_a + 1;
    if (done_a)  ndone_a  <= ndone_a + 1;

    if (sclk_b && !prev_sclk_b) begin
      rx_b    <= {sdata_b, rx_b[31:1]};
      nbits_b <= nbits_b + 1;
    end
    prev_sclk_b <= sclk_b;
    if (latch_b) nlatch_b <= nlatch_b + 1;
    if (done_b)  ndone_b  <= ndone_b + 1;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic kick_a(input logic [31:0] w);
    pdata_a = w;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc     = 1;
  endtask

  // Expected {busy, sclk, latch, done, sdata} at selected cycles of a
  // 0xA5C30F81 transfer, MSB first, DIV=2 (bit b occupies cycles 4b+1..4b+4,
  // sclk high in the last two).
  typedef struct {
    int         cyc;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[19];

  int base_l, base_d, base_n;

  initial begin
    tbl[0]  = '{cyc:1,   exp:5'b10001};
    tbl[1]  = '{cyc:3,   exp:5'b11001};
    tbl[2]  = '{cyc:5,   exp:5'b10000};
    tbl[3]  = '{cyc:8,   exp:5'b11000};
    tbl[4]  = '{cyc:9,   exp:5'b10001};
    tbl[5]  = '{cyc:33,  exp:5'b10001};
    tbl[6]  = '{cyc:35,  exp:5'b11001};
    tbl[7]  = '{cyc:65,  exp:5'b10000};
    tbl[8]  = '{cyc:67,  exp:5'b11000};
    tbl[9]  = '{cyc:81,  exp:5'b10001};
    tbl[10] = '{cyc:97,  exp:5'b10001};
    tbl[11] = '{cyc:101, exp:5'b10000};
    tbl[12] = '{cyc:125, exp:5'b10001};
    tbl[13] = '{cyc:127, exp:5'b11001};
    tbl[14] = '{cyc:128, exp:5'b11001};
    tbl[15] = '{cyc:129, exp:5'b10100};
    tbl[16] = '{cyc:130, exp:5'b10100};
    tbl[17] = '{cyc:131, exp:5'b00010};
    tbl[18] = '{cyc:132, exp:5'b00000};

    // Reset held with start asserted: nothing may start.
    rst_a   = 1'b1;
    start_a = 1'b1;
    pdata_a = 32'hA5C3_0F81;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_outs_%0d", i),
          32'({busy_a, sclk_a, latch_a, done_a, sdata_a}), 32'h0);
    end

    // Release reset, one-cycle start, then the word check vectors.
    rst_a  = 1'b0;
    base_l = nlatch_a;
    base_d = ndone_a;
    base_n = nbits_a;
    kick_a(32'hA5C3_0F81);
    chk("busy_after_start", 32'(busy_a), 32'h1);
    for (int i = 0; i < 19; i++) begin
      run_to(tbl[i].cyc);
      chk($sformatf("vec_c%0d", tbl[i].cyc),
          32'({busy_a, sclk_a, latch_a, done_a, sdata_a}), 32'(tbl[i].exp));
    end
    chk("word_msb", rx_a, 32'hA5C3_0F81);
    chk("word_nbits", 32'(nbits_a - base_n), 32'd32);
    chk("word_latch_cycles", 32'(nlatch_a - base_l), 32'd2);
    chk("word_done_pulses", 32'(ndone_a - base_d), 32'd1);

    // Start while busy: ignored, word and PData change have no effect.
    run_to(140);
    base_d = ndone_a;
    kick_a(32'h1234_5678);
    run_to(40);
    pdata_a = 32'hFFFF_FFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_to(131);
    chk("busy_ign_done", 32'(done_a), 32'h1);
    run_to(140);
    chk("busy_ign_word", rx_a, 32'h1234_5678);
    chk("busy_ign_ndone", 32'(ndone_a - base_d), 32'd1);
    chk("busy_ign_idle", 32'(busy_a), 32'h0);

    // Back-to-back: start held high, second word captured in the FIN cycle.
    base_d  = ndone_a;
    pdata_a = 32'h0000_0001;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    cyc     = 1;
    pdata_a = 32'h0000_0002;
    run_to(130);
    chk("b2b_busy_130", 32'(busy_a), 32'h1);
    tick();
    chk("b2b_fin_131", 32'({busy_a, done_a}), 32'b01);
    chk("b2b_word1", rx_a, 32'h0000_0001);
    tick();
    start_a = 1'b0;
    chk("b2b_busy_132", 32'(busy_a), 32'h1);
    run_to(262);
    chk("b2b_fin_262", 32'({busy_a, done_a}), 32'b01);
    chk("b2b_word2", rx_a, 32'h0000_0002);
    tick();
    chk("b2b_ndone", 32'(ndone_a - base_d), 32'd2);

    // Reset mid-transfer: outputs clear next cycle, no latch/done follows.
    run_to(270);
    kick_a(32'hDEAD_BEEF);
    run_to(50);
    rst_a = 1'b1;
    tick();
    chk("midrst_outs", 32'({busy_a, sclk_a, latch_a, done_a, sdata_a}), 32'h0);
    rst_a  = 1'b0;
    base_l = nlatch_a;
    base_d = ndone_a;
    run_to(200);
    chk("midrst_nlatch", 32'(nlatch_a - base_l), 32'd0);
    chk("midrst_ndone", 32'(ndone_a - base_d), 32'd0);
    chk("midrst_idle", 32'(busy_a), 32'h0);
    kick_a(32'h0F0F_0F0F);
    run_to(131);
    chk("post_rst_done", 32'(done_a), 32'h1);
    chk("post_rst_word", rx_a, 32'h0F0F_0F0F);

    // LSB first, DIV=1: bit b in cycles 2b+1..2b+2, latch at 65, done at 66.
    run_to(140);
    rst_b   = 1'b0;
    tick();
    base_l  = nlatch_b;
    base_d  = ndone_b;
    base_n  = nbits_b;
    pdata_b = 32'h0000_0001;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc     = 1;
    chk("lsb_c1", 32'({busy_b, sclk_b, sdata_b}), 32'b101);
    tick();
    chk("lsb_c2", 32'({busy_b, sclk_b, sdata_b}), 32'b111);
    tick();
    chk("lsb_c3", 32'({busy_b, sclk_b, sdata_b}), 32'b100);
    chk("lsb_first_bit", 32'(rx_b[31]), 32'h1);
    run_to(64);
    chk("lsb_c64", 32'({busy_b, sclk_b, latch_b}), 32'b110);
    tick();
    chk("lsb_latch_65", 32'({busy_b, sclk_b, latch_b, sdata_b}), 32'b1010);
    tick();
    chk("lsb_done_66", 32'({busy_b, done_b, latch_b}), 32'b010);
    tick();
    chk("lsb_idle_67", 32'({busy_b, done_b}), 32'b00);
    chk("lsb_word", rx_b, 32'h0000_0001);
    chk("lsb_nbits", 32'(nbits_b - base_n), 32'd32);
    chk("lsb_nlatch", 32'(nlatch_b - base_l), 32'd1);
    chk("lsb_ndone", 32'(ndone_b - base_d), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_shift_out.md
# serial_shift_out

Parallel-to-serial output stage downstream of the 32-bit up/down counter. On a start request it captures a parallel word (normally the counter's `cnt`, with the counter's `Rc` usable as `start`). It shifts the word out on a serial data/clock pair for the board's shift-register LED/segment chain, then pulses a latch strobe. The block is a single-clock FSM with a programmable serial-clock divider and a busy/done handshake.

## Interface
- `WIDTH`, 32: bits per transfer; ≥ 2.
- `DIV`, 2: `clk` cycles per `sclk` half-period; ≥ 1.
- `MSB_FIRST`, 1: 1 = shift MSB first, 0 = LSB first.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  transfer request, sampled each edge.
- `PData`  in  WIDTH  word to send, captured when `start` is accepted.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.
- `sdata`  out  1  serial data.
- `sclk`  out  1  serial clock; downstream samples on its rising edge.
- `latch`  out  1  parallel-load strobe for the downstream chain.

## Operation
- States: IDLE, LOW, HIGH, LATCH, FIN.
- **IDLE**
  - `busy`=0, `sclk`=0, `latch`=0.
  - `start`=1 → capture `PData` into the shift register, set bit counter = WIDTH, set phase counter = 0, go to LOW.
- **LOW**
  - `sclk`=0. `sdata` = current head bit: `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
  - After DIV cycles → HIGH.
- **HIGH**
  - `sclk`=1. `sdata` is unchanged.
  - After DIV cycles:
    - shift register moves one place toward the head (MSB_FIRST: left shift, 0 fill; otherwise right shift, 0 fill);
    - bit counter decrements;
    - bit counter was 1 → LATCH; otherwise → LOW.
- **LATCH**
  - `latch`=1, `sclk`=0, `sdata`=0.
  - After DIV cycles → FIN.
- **FIN**
  - `done`=1, `busy`=0, for exactly one cycle → IDLE.
  - `start` in the FIN cycle is accepted exactly as in IDLE; FIN then goes directly to LOW (back-to-back transfer).
- `busy`=1 in LOW, HIGH and LATCH.
- `start` while `busy`=1 is ignored. There is no queueing, and the captured word is not disturbed.
- `PData` changes after capture have no effect.
- Phase counter: width `$clog2(DIV)` (min 1). It counts 0..DIV-1 and clears on every state change.
- Bit counter: width `$clog2(WIDTH+1)`. It never wraps: the exit condition is a value of 1 at the end of HIGH.
- `rst`=1 at any edge, including mid-transfer:
  - next state IDLE;
  - `busy`=0, `done`=0, `sdata`=0, `sclk`=0, `latch`=0;
  - shift register and both counters cleared.
  - The partial transfer is abandoned; no `latch` or `done` is produced.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.

## Timing
- All outputs are registered; their values change only on `clk` rising edges.
- Reset values: `busy`=0, `done`=0, `sdata`=0, `sclk`=0, `latch`=0.
- Define `start` as sampled at edge 0. Then:
  - `busy`=1 from cycle 1;
  - first `sdata` bit is valid from cycle 1;
  - first `sclk` rise is at cycle 1+DIV.
- Each bit takes 2·DIV cycles. `sdata` is stable for DIV cycles before and DIV cycles after each `sclk` rise.
- `latch` is high for cycles 1+2·DIV·WIDTH through 2·DIV·WIDTH+DIV.
- `done` pulses at cycle 2·DIV·WIDTH+DIV+1, with `busy`=0 in that cycle.
- Defaults (WIDTH=32, DIV=2): `busy` cycles 1..130, `latch` cycles 129..130, `done` at cycle 131.
- Minimum start-to-start spacing is 2·DIV·WIDTH+DIV+1 cycles.

## Structure
- Package `serial_out_pkg`:
  - state enum typedef (IDLE, LOW, HIGH, LATCH, FIN);
  - localparam functions for phase-counter and bit-counter widths.
- Sub-module `sclk_phase_gen`:
  - DIV-cycle phase counter with a `clear` input and a `tick` output (high on the last phase cycle);
  - one instance, driven by the FSM.
- Top module `serial_shift_out` contains the FSM, the shift register, the bit counter and the output registers.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `start`=1 → all outputs 0, no transfer starts. Release `rst`, drive `start` one cycle → `busy` at the next cycle.
- **Word check:** WIDTH=32, DIV=2, MSB_FIRST=1, `PData`=0xA5C3_0F81. Capture `sdata` on each `sclk` rise → 32 bits equal 0xA5C30F81. `latch` high in cycles 129–130, `done` at 131.
- **LSB first:** MSB_FIRST=0, DIV=1, `PData`=0x0000_0001 → first captured bit is 1, remaining 31 bits 0. `done` at cycle 66.
- **Start while busy:** pulse `start` at cycle 40 with `PData` changed to 0xFFFF_FFFF → ignored; serial output still matches the original word; no second transfer.
- **Back-to-back:** hold `start`=1 continuously, `PData` 0x1 then 0x2 → the second transfer begins in the FIN cycle. `busy` drops for exactly the one `done` cycle. Both words are received intact.
- **Reset mid-transfer:** assert `rst` at cycle 50 of a transfer → the next cycle has all outputs 0. No `latch` or `done` pulse. A new `start` afterwards completes normally.
